// File: rtl/control_datapath_unit_pkg.sv
// Shared definitions for the serial transmitter control/datapath slice.
//   - default data width and bit-counter width
//   - FSM state encoding (idle=0, waiting=1, sending=2)
package control_datapath_unit_pkg;

    localparam int DEFAULT_WORD_SIZE = 8;
    localparam int DEFAULT_BC_SIZE   = 4;

    typedef logic [1:0] xmt_state_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAITING = 2'd1;
    localparam logic [1:0] ST_SENDING = 2'd2;

endpackage

// File: rtl/xmt_control_fsm.sv
// Transmit controller FSM (idle / waiting / sending).
// Ports:
//   Clock             in   rising-edge clock
//   rst_b             in   synchronous active-high reset
//   Load_XMT_datareg  in   request to capture Data_Bus into the holding register
//   Byte_ready        in   holding register valid, move it into the shift register
//   T_byte            in   begin transmitting the byte sitting in the shift register
//   BC_It_BCmax       in   1 while bit_count < WORD_SIZE+1 (more shifts to do)
//   Load_XMT_DR       out  strobe: load holding register
//   Load_XMT_shiftreg out  strobe: load shift register from holding register
//   start             out  strobe: drive the start bit
//   shift             out  strobe: shift one bit out, count it
//   clear             out  strobe: clear bit counter at end of frame
//   state             out  current FSM state (debug visibility)
//
// Handshake: the inputs are level requests, not valid/ready pairs. A request
// is consumed on the rising edge where the FSM is in the state that accepts
// it (Load_XMT_datareg/Byte_ready in idle, T_byte in waiting); in any other
// state the request is ignored and has no lasting effect. Holding
// Byte_ready and T_byte high therefore streams frames back to back.
module xmt_control_fsm
    import control_datapath_unit_pkg::*;
(
    input  logic       Clock,
    input  logic       rst_b,
    input  logic       Load_XMT_datareg,
    input  logic       Byte_ready,
    input  logic       T_byte,
    input  logic       BC_It_BCmax,
    output logic       Load_XMT_DR,
    output logic       Load_XMT_shiftreg,
    output logic       start,
    output logic       shift,
    output logic       clear,
    output xmt_state_t state
);

    xmt_state_t next_state;

    always_ff @(posedge Clock) begin
        if (rst_b) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Mealy decode: each branch raises at most one strobe.
    always_comb begin
        next_state        = state;
        Load_XMT_DR       = 1'b0;
        Load_XMT_shiftreg = 1'b0;
        start             = 1'b0;
        shift             = 1'b0;
        clear             = 1'b0;
        case (state)
            ST_IDLE: begin
                // A data-register load wins over Byte_ready so the byte
                // being written is never bypassed by a stale one.
                if (Load_XMT_datareg) begin
                    Load_XMT_DR = 1'b1;
                end else if (Byte_ready) begin
                    Load_XMT_shiftreg = 1'b1;
                    next_state        = ST_WAITING;
                end
            end
            ST_WAITING: begin
                if (T_byte) begin
                    start      = 1'b1;
                    next_state = ST_SENDING;
                end
            end
            ST_SENDING: begin
                if (BC_It_BCmax) begin
                    shift = 1'b1;
                end else begin
                    clear      = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/control_datapath_unit.sv
// Serial byte transmitter: holding register, start/data/stop shift register
// and bit counter, sequenced by xmt_control_fsm.
// Line format: one start bit (0), WORD_SIZE data bits LSB first, then 1.
// Ports:
//   Clock             in   rising-edge clock
//   rst_b             in   synchronous active-high reset
//   Data_Bus          in   byte to transmit
//   Load_XMT_datareg  in   load Data_Bus into the holding register (idle only)
//   Byte_ready        in   move holding register into the shift register (idle only)
//   T_byte            in   start transmission (waiting only)
//   Serial_out        out  serial line, idle high
//   fsm_state         out  controller state (debug visibility)
module control_datapath_unit
    import control_datapath_unit_pkg::*;
#(
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
    parameter int BC_SIZE   = DEFAULT_BC_SIZE
) (
    input  logic                 Clock,
    input  logic                 rst_b,
    input  logic [WORD_SIZE-1:0] Data_Bus,
    input  logic                 Load_XMT_datareg,
    input  logic                 Byte_ready,
    input  logic                 T_byte,
    output logic                 Serial_out,
    output xmt_state_t           fsm_state
);

    // WORD_SIZE+1 shifts push out the WORD_SIZE data bits plus the stop bit.
    localparam logic [BC_SIZE-1:0] BC_MAX = BC_SIZE'(WORD_SIZE + 1);

    logic [WORD_SIZE-1:0] XMT_datareg;
    logic [WORD_SIZE:0]   XMT_shftreg;
    logic [BC_SIZE-1:0]   bit_count;

    logic Load_XMT_DR;
    logic Load_XMT_shiftreg;
    logic start;
    logic shift;
    logic clear;
    logic BC_It_BCmax;

    assign BC_It_BCmax = (bit_count < BC_MAX);
    assign Serial_out  = XMT_shftreg[0];

    xmt_control_fsm u_fsm (
        .Clock             (Clock),
        .rst_b             (rst_b),
        .Load_XMT_datareg  (Load_XMT_datareg),
        .Byte_ready        (Byte_ready),
        .T_byte            (T_byte),
        .BC_It_BCmax       (BC_It_BCmax),
        .Load_XMT_DR       (Load_XMT_DR),
        .Load_XMT_shiftreg (Load_XMT_shiftreg),
        .start             (start),
        .shift             (shift),
        .clear             (clear),
        .state             (fsm_state)
    );

    always_ff @(posedge Clock) begin
        if (rst_b) begin
            XMT_datareg <= '0;
            XMT_shftreg <= '1;
            bit_count   <= '0;
        end else begin
            if (Load_XMT_DR) begin
                XMT_datareg <= Data_Bus;
            end
            // Bit 0 is loaded with 1 so the line stays idle until start.
            if (Load_XMT_shiftreg) begin
                XMT_shftreg <= {XMT_datareg, 1'b1};
            end
            if (start) begin
                XMT_shftreg[0] <= 1'b0;
            end
            // Ones fill from the top so the line ends on the stop level.
            if (shift) begin
                XMT_shftreg <= {1'b1, XMT_shftreg[WORD_SIZE:1]};
                bit_count   <= bit_count + 1'b1;
            end
            if (clear) begin
                bit_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_control_datapath_unit.sv
// Directed bench for control_datapath_unit (WORD_SIZE=8, BC_SIZE=4).
module tb_control_datapath_unit;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAITING = 2'd1;
    localparam logic [1:0] S_SENDING = 2'd2;

    logic       Clock;
    logic       rst_b;
    logic [7:0] Data_Bus;
    logic       Load_XMT_datareg;
    logic       Byte_ready;
    logic       T_byte;
    logic       Serial_out;
    logic [1:0] fsm_state;

    int n_tests;
    int n_fail;

    control_datapath_unit #(
        .WORD_SIZE (8),
        .BC_SIZE   (4)
    ) dut (
        .Clock            (Clock),
        .rst_b            (rst_b),
        .Data_Bus         (Data_Bus),
        .Load_XMT_datareg (Load_XMT_datareg),
        .Byte_ready       (Byte_ready),
        .T_byte           (T_byte),
        .Serial_out       (Serial_out),
        .fsm_state        (fsm_state)
    );

    // ---------------- clock ----------------
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one rising edge, then settle so outputs are sampled off-edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_byte(input logic [7:0] d);
        Data_Bus         = d;
        Load_XMT_datareg = 1'b1;
        tick();
        Load_XMT_datareg = 1'b0;
        check("load_datareg", 32'(dut.XMT_datareg), 32'(d));
        check("load_state_idle", 32'(fsm_state), 32'(S_IDLE));
    endtask

    // Sends the byte already in the holding register and checks every line
    // bit. With corrupt=1 the data bus and load request are disturbed while
    // the frame is in flight.
    task automatic run_frame(input logic [7:0] d, input bit corrupt);
        Byte_ready = 1'b1;
        tick();
        Byte_ready = 1'b0;
        check("frame_waiting_state", 32'(fsm_state), 32'(S_WAITING));
        check("frame_waiting_line", 32'(Serial_out), 32'(1));
        T_byte = 1'b1;
        tick();
        T_byte = 1'b0;
        check("frame_start_bit", 32'(Serial_out), 32'(0));
        check("frame_sending_state", 32'(fsm_state), 32'(S_SENDING));
        if (corrupt) begin
            Data_Bus         = 8'h00;
            Load_XMT_datareg = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("frame_data_bit%0d", i), 32'(Serial_out), 32'(d[i]));
            Load_XMT_datareg = 1'b0;
        end
        tick();
        check("frame_stop_bit", 32'(Serial_out), 32'(1));
        check("frame_stop_state", 32'(fsm_state), 32'(S_SENDING));
        tick();
        check("frame_end_state", 32'(fsm_state), 32'(S_IDLE));
        check("frame_end_line", 32'(Serial_out), 32'(1));
        check("frame_end_count", 32'(dut.bit_count), 32'(0));
    endtask

    initial begin
        logic [7:0] b2b;
        n_tests          = 0;
        n_fail           = 0;
        rst_b            = 1'b1;
        Data_Bus         = 8'h00;
        Load_XMT_datareg = 1'b0;
        Byte_ready       = 1'b0;
        T_byte           = 1'b0;

        // Reset held 3 cycles; line must be high from the first edge.
        tick();
        check("reset_first_edge_line", 32'(Serial_out), 32'(1));
        tick();
        tick();
        check("reset_line", 32'(Serial_out), 32'(1));
        check("reset_state", 32'(fsm_state), 32'(S_IDLE));
        check("reset_count", 32'(dut.bit_count), 32'(0));
        check("reset_datareg", 32'(dut.XMT_datareg), 32'(0));
        rst_b = 1'b0;
        tick();
        check("idle_line", 32'(Serial_out), 32'(1));

        // Basic frame: 0xA7 -> 0,1,1,1,0,0,1,0,1 then 1.
        load_byte(8'hA7);
        run_frame(8'hA7, 1'b0);

        // Load and Byte_ready together: only the data register loads.
        Data_Bus         = 8'h3C;
        Load_XMT_datareg = 1'b1;
        Byte_ready       = 1'b1;
        tick();
        Load_XMT_datareg = 1'b0;
        Byte_ready       = 1'b0;
        check("prio_state_idle", 32'(fsm_state), 32'(S_IDLE));
        check("prio_datareg", 32'(dut.XMT_datareg), 32'(8'h3C));
        check("prio_line", 32'(Serial_out), 32'(1));

        // Bus disturbed mid-frame: bits and held byte unchanged.
        load_byte(8'hA7);
        run_frame(8'hA7, 1'b1);
        check("disturb_datareg_kept", 32'(dut.XMT_datareg), 32'(8'hA7));

        // Reset on the 4th data bit aborts the frame.
        load_byte(8'h5A);
        Byte_ready = 1'b1;
        tick();
        Byte_ready = 1'b0;
        T_byte = 1'b1;
        tick();
        T_byte = 1'b0;
        check("abort_start_bit", 32'(Serial_out), 32'(0));
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("abort_data_bit%0d", i), 32'(Serial_out), 32'((8'h5A >> i) & 8'h01));
        end
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        check("abort_line", 32'(Serial_out), 32'(1));
        check("abort_state", 32'(fsm_state), 32'(S_IDLE));
        check("abort_count", 32'(dut.bit_count), 32'(0));
        tick();
        check("abort_idle_line", 32'(Serial_out), 32'(1));
        load_byte(8'h96);
        run_frame(8'h96, 1'b0);

        // Byte_ready and T_byte held: three identical back-to-back frames.
        b2b = 8'hC3;
        load_byte(b2b);
        Byte_ready = 1'b1;
        T_byte     = 1'b1;
        for (int f = 0; f < 3; f++) begin
            tick();
            check($sformatf("b2b%0d_waiting", f), 32'(fsm_state), 32'(S_WAITING));
            check($sformatf("b2b%0d_idle_line", f), 32'(Serial_out), 32'(1));
            tick();
            check($sformatf("b2b%0d_start", f), 32'(Serial_out), 32'(0));
            for (int i = 0; i < 8; i++) begin
                tick();
                check($sformatf("b2b%0d_bit%0d", f, i), 32'(Serial_out), 32'(b2b[i]));
            end
            tick();
            check($sformatf("b2b%0d_stop", f), 32'(Serial_out), 32'(1));
            tick();
            check($sformatf("b2b%0d_idle", f), 32'(fsm_state), 32'(S_IDLE));
            check($sformatf("b2b%0d_clear_line", f), 32'(Serial_out), 32'(1));
        end
        Byte_ready = 1'b0;
        T_byte     = 1'b0;
        tick();
        check("final_idle_state", 32'(fsm_state), 32'(S_IDLE));
        check("final_idle_line", 32'(Serial_out), 32'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
